// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and round functions.
// SHA256_SHA224_MODE_EN (optional) uses IV224 for SHA-224 digests.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int NUM_ROUNDS = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ROUNDS = 2'b01,
    ST_UPDATE = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  // Working variables a..h; the same layout holds H0..H7 so a struct add gives the update.
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } work_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV256 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t IV224 [0:7] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic bit unroll_legal(input int u);
    return (u == 1) || (u == 2) || (u == 4) || (u == 8);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic word_t bsig0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic word_t bsig1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic word_t ssig0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic work_t iv_state(input logic sel224);
    work_t s;
    if (sel224) s = {IV224[0], IV224[1], IV224[2], IV224[3], IV224[4], IV224[5], IV224[6], IV224[7]};
    else        s = {IV256[0], IV256[1], IV256[2], IV256[3], IV256[4], IV256[5], IV256[6], IV256[7]};
    return s;
  endfunction

  function automatic work_t add_state(input work_t x, input work_t y);
    work_t s;
    s.a = x.a + y.a;
    s.b = x.b + y.b;
    s.c = x.c + y.c;
    s.d = x.d + y.d;
    s.e = x.e + y.e;
    s.f = x.f + y.f;
    s.g = x.g + y.g;
    s.h = x.h + y.h;
    return s;
  endfunction

endpackage

// File: rtl/sha256_stream_core_if.sv
// Block-in / digest-out stream bundle for sha256_stream_core.
// SHA256_SHA224_MODE_EN adds the sha224_sel message-type select.
interface sha256_stream_core_if;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block_data;
  logic         block_last;
  logic         abort;
  logic         digest_valid;
  logic         digest_ready;
  logic [255:0] digest;
`ifdef SHA256_SHA224_MODE_EN
  logic         sha224_sel;
`endif

  modport master (
`ifdef SHA256_SHA224_MODE_EN
    output sha224_sel,
`endif
    output block_valid, block_data, block_last, abort, digest_ready,
    input  block_ready, digest_valid, digest
  );

  modport slave (
`ifdef SHA256_SHA224_MODE_EN
    input  sha224_sel,
`endif
    input  block_valid, block_data, block_last, abort, digest_ready,
    output block_ready, digest_valid, digest
  );
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; chained UNROLL times by the core.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t in_s,
  input  word_t kt,
  input  word_t wt,
  output work_t out_s
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1 = in_s.h + bsig1(in_s.e) + ch(in_s.e, in_s.f, in_s.g) + kt + wt;
    t2 = bsig0(in_s.a) + maj(in_s.a, in_s.b, in_s.c);
    out_s.a = t1 + t2;
    out_s.b = in_s.a;
    out_s.c = in_s.b;
    out_s.d = in_s.c;
    out_s.e = in_s.d + t1;
    out_s.f = in_s.e;
    out_s.g = in_s.f;
    out_s.h = in_s.g;
  end

endmodule

// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256 core, UNROLL rounds per clock, valid/ready block and digest ports.
// Define SHA256_SHA224_MODE_EN to add per-message SHA-224 selection.
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sha256_stream_core_if.slave    bus,
  output logic [1:0]             q_state
);

  if (!unroll_legal(UNROLL)) begin : g_bad_unroll
    $error("sha256_stream_core: UNROLL must be 1, 2, 4 or 8");
  end
  if ((NUM_ROUNDS % UNROLL) != 0) begin : g_bad_rounds
    $error("sha256_stream_core: NUM_ROUNDS must be a multiple of UNROLL");
  end

  state_e        state_q, state_d;
  work_t         work_q, work_d;
  work_t         h_q, h_d;
  word_t         w_q [16];
  word_t         w_d [16];
  logic [5:0]    round_cnt_q, round_cnt_d;
  logic          last_q, last_d;
  logic          msg_active_q, msg_active_d;
  logic [255:0]  digest_q, digest_d;
  logic          digest_valid_q, digest_valid_d;
  logic          sel224_q, sel224_d;
  logic          sel224_in;

  word_t         ext [16 + UNROLL];
  word_t         w_next [16];
  work_t         chain [UNROLL + 1];
  work_t         h_new;
  logic          xfer;

`ifdef SHA256_SHA224_MODE_EN
  assign sel224_in = bus.sha224_sel;
`else
  assign sel224_in = 1'b0;
`endif

  // abort blocks acceptance in the same cycle so the aborted message cannot absorb a block.
  assign bus.block_ready  = (state_q == ST_IDLE) && !bus.abort;
  assign bus.digest_valid = digest_valid_q;
  assign bus.digest       = digest_q;
  assign q_state          = state_q;
  assign xfer             = bus.block_valid && bus.block_ready;
  assign h_new            = add_state(h_q, work_q);

  // Schedule window: ext[0] is W[round_cnt]; UNROLL new words are appended and the window slides.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int j = 0; j < UNROLL; j++) begin
      ext[16 + j] = ssig1(ext[14 + j]) + ext[9 + j] + ssig0(ext[1 + j]) + ext[j];
    end
    for (int i = 0; i < 16; i++) w_next[i] = ext[i + UNROLL];
  end

  assign chain[0] = work_q;

  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
    sha256_round u_round (
      .in_s  (chain[gi]),
      .kt    (K[round_cnt_q + 6'(gi)]),
      .wt    (ext[gi]),
      .out_s (chain[gi + 1])
    );
  end

  always_comb begin
    state_d        = state_q;
    work_d         = work_q;
    h_d            = h_q;
    w_d            = w_q;
    round_cnt_d    = round_cnt_q;
    last_d         = last_q;
    msg_active_d   = msg_active_q;
    digest_d       = digest_q;
    digest_valid_d = digest_valid_q;
    sel224_d       = sel224_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.abort) begin
          msg_active_d = 1'b0;
        end else if (xfer) begin
          for (int i = 0; i < 16; i++) w_d[i] = bus.block_data[511 - 32*i -: 32];
          last_d = bus.block_last;
          if (!msg_active_q) begin
            h_d      = iv_state(sel224_in);
            work_d   = iv_state(sel224_in);
            sel224_d = sel224_in;
          end else begin
            work_d = h_q;
          end
          msg_active_d = 1'b1;
          round_cnt_d  = '0;
          state_d      = ST_ROUNDS;
        end
      end
      ST_ROUNDS: begin
        if (bus.abort) begin
          msg_active_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          work_d      = chain[UNROLL];
          w_d         = w_next;
          round_cnt_d = round_cnt_q + 6'(UNROLL);
          if (round_cnt_q == 6'(NUM_ROUNDS - UNROLL)) state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (bus.abort) begin
          msg_active_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          h_d = h_new;
          if (last_q) begin
            digest_d = h_new;
            if (sel224_q) digest_d[31:0] = '0;
            digest_valid_d = 1'b1;
            msg_active_d   = 1'b0;
            state_d        = ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        if (bus.digest_ready) begin
          digest_valid_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      work_q         <= '0;
      h_q            <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      round_cnt_q    <= '0;
      last_q         <= 1'b0;
      msg_active_q   <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      sel224_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      work_q         <= work_d;
      h_q            <= h_d;
      w_q            <= w_d;
      round_cnt_q    <= round_cnt_d;
      last_q         <= last_d;
      msg_active_q   <= msg_active_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      sel224_q       <= sel224_d;
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Directed bench: three cores (UNROLL 1, 2, 4) exercised one at a time with known SHA-256 vectors.
module tb_sha256_stream_core;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_HELLO = {32'h68656c6c, 32'h6f20776f, 32'h726c6480, 384'h0, 32'h00000058};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_M1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
    32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071,
    32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_M2 = {480'h0, 32'h000001c0};

  localparam logic [255:0] DG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DG_HELLO = 256'hb94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9;
  localparam logic [255:0] DG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] DG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         vld [3];
  logic [511:0] data;
  logic         last;
  logic         abort;
  logic         dready;
  logic         sel224;
  logic         rdy [3];
  logic         dv [3];
  logic [255:0] dg [3];
  logic [1:0]   qs [3];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           unr [3] = '{1, 2, 4};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_stream_core_if bus1 ();
  sha256_stream_core_if bus2 ();
  sha256_stream_core_if bus4 ();

  assign bus1.block_valid = vld[0];
  assign bus2.block_valid = vld[1];
  assign bus4.block_valid = vld[2];
  assign bus1.block_data = data;   assign bus2.block_data = data;   assign bus4.block_data = data;
  assign bus1.block_last = last;   assign bus2.block_last = last;   assign bus4.block_last = last;
  assign bus1.abort = abort;       assign bus2.abort = abort;       assign bus4.abort = abort;
  assign bus1.digest_ready = dready; assign bus2.digest_ready = dready; assign bus4.digest_ready = dready;
`ifdef SHA256_SHA224_MODE_EN
  assign bus1.sha224_sel = sel224; assign bus2.sha224_sel = sel224; assign bus4.sha224_sel = sel224;
`endif
  assign rdy[0] = bus1.block_ready;  assign rdy[1] = bus2.block_ready;  assign rdy[2] = bus4.block_ready;
  assign dv[0]  = bus1.digest_valid; assign dv[1]  = bus2.digest_valid; assign dv[2]  = bus4.digest_valid;
  assign dg[0]  = bus1.digest;       assign dg[1]  = bus2.digest;       assign dg[2]  = bus4.digest;

  sha256_stream_core #(.UNROLL(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1), .q_state(qs[0]));
  sha256_stream_core #(.UNROLL(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2), .q_state(qs[1]));
  sha256_stream_core #(.UNROLL(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4), .q_state(qs[2]));

  task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a block at a negedge and returns the cycle count seen just after the accepting edge.
  task automatic send_block(input int d, input logic [511:0] blk, input logic lst, output int acc);
    acc = -1;
    @(negedge clk);
    data = blk;
    last = lst;
    vld[d] = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (rdy[d] === 1'b1) begin
        @(negedge clk);
        acc = cyc;
        vld[d] = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      vld[d] = 1'b0;
      check_output("accept_timeout", 256'(0), 256'(1));
    end
  endtask

  task automatic wait_digest(input int d, output int t);
    t = -1;
    for (int n = 0; n < 300; n++) begin
      if (dv[d] === 1'b1) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) check_output("digest_timeout", 256'(0), 256'(1));
  endtask

  task automatic release_digest(input int d, input logic [255:0] exp);
    dready = 1'b1;
    @(negedge clk);
    dready = 1'b0;
    check_output("release_valid", 256'(dv[d]), 256'(0));
    check_output("release_state", 256'(qs[d]), 256'(0));
    check_output("release_retain", dg[d], exp);
  endtask

  task automatic run_single(input int d, input string tag, input logic [511:0] blk, input logic [255:0] exp);
    int a0, t0;
    send_block(d, blk, 1'b1, a0);
    wait_digest(d, t0);
    check_output({tag, "_latency"}, 256'(t0 - a0), 256'(64 / unr[d] + 1));
    check_output({tag, "_digest"}, dg[d], exp);
    check_output({tag, "_ready_in_done"}, 256'(rdy[d]), 256'(0));
    release_digest(d, exp);
  endtask

  initial begin
    int a0, a1, t0, ex;
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    data = '0; last = 1'b0; abort = 1'b0; dready = 1'b0; sel224 = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_output("reset_digest", dg[d], 256'(0));
      check_output("reset_valid", 256'(dv[d]), 256'(0));
      check_output("reset_state", 256'(qs[d]), 256'(0));
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_output("idle_ready", 256'(rdy[d]), 256'(1));

    for (int d = 0; d < 3; d++) begin
      $display("[TB] core with UNROLL=%0d", unr[d]);
      run_single(d, "abc", BLK_ABC, DG_ABC);
      run_single(d, "hello", BLK_HELLO, DG_HELLO);

      // Two-block message, then a stalled consumer.
      send_block(d, BLK_M1, 1'b0, a0);
      send_block(d, BLK_M2, 1'b1, a1);
      check_output("two_spacing", 256'(a1 - a0), 256'(64 / unr[d] + 2));
      wait_digest(d, t0);
      check_output("two_latency", 256'(t0 - a1), 256'(64 / unr[d] + 1));
      for (int n = 0; n < 10; n++) begin
        check_output("stall_digest", dg[d], DG_TWO);
        check_output("stall_ready", {254'(0), rdy[d], dv[d]}, 256'(1));
        @(negedge clk);
      end
      release_digest(d, DG_TWO);

      // Abort a message mid-rounds, then check abort beats a simultaneous block in IDLE.
      send_block(d, BLK_ABC, 1'b1, a0);
      repeat (4) @(negedge clk);
      check_output("pre_abort_state", 256'(qs[d]), 256'(1));
      abort = 1'b1;
      @(negedge clk);
      check_output("post_abort_state", 256'(qs[d]), 256'(0));
      vld[d] = 1'b1;
      data = BLK_HELLO;
      check_output("abort_blocks_ready", 256'(rdy[d]), 256'(0));
      @(negedge clk);
      vld[d] = 1'b0;
      abort = 1'b0;
      check_output("abort_no_accept", 256'(qs[d]), 256'(0));
      check_output("abort_no_digest", 256'(dv[d]), 256'(0));
      run_single(d, "empty", BLK_EMPTY, DG_EMPTY);

      // Back-to-back messages with block_valid held high throughout.
      @(negedge clk);
      data = BLK_ABC;
      last = 1'b1;
      vld[d] = 1'b1;
      wait_digest(d, t0);
      check_output("b2b_first", dg[d], DG_ABC);
      check_output("b2b_ready_done", 256'(rdy[d]), 256'(0));
      dready = 1'b1;
      @(negedge clk);
      dready = 1'b0;
      ex = cyc;
      check_output("b2b_exit_state", 256'(qs[d]), 256'(0));
      @(negedge clk);
      check_output("b2b_second_accept", 256'(qs[d]), 256'(1));
      check_output("b2b_accept_time", 256'(cyc - ex), 256'(1));
      vld[d] = 1'b0;
      wait_digest(d, t0);
      check_output("b2b_second", dg[d], DG_ABC);
      release_digest(d, DG_ABC);
    end

`ifdef SHA256_SHA224_MODE_EN
    sel224 = 1'b1;
    send_block(0, BLK_ABC, 1'b1, a0);
    sel224 = 1'b0;
    wait_digest(0, t0);
    check_output("sha224_high", 256'(dg[0][255:32]),
                 256'(224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7));
    check_output("sha224_low", 256'(dg[0][31:0]), 256'(0));
    release_digest(0, dg[0]);
    run_single(0, "abc_after_224", BLK_ABC, DG_ABC);
`endif

    // Asynchronous reset in the middle of rounds.
    send_block(1, BLK_ABC, 1'b1, a0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_output("midreset_digest", dg[1], 256'(0));
    check_output("midreset_valid", 256'(dv[1]), 256'(0));
    check_output("midreset_state", 256'(qs[1]), 256'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_output("midreset_idle", 256'(qs[1]), 256'(0));
    run_single(1, "abc_after_reset", BLK_ABC, DG_ABC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
